// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects, register enables and memory write enable.
module mips_control_fsm #(
    parameter int unsigned S_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [5:0]     OpCode,
    input  logic [5:0]     Funct,
    output logic           IorD,
    output logic           RegDST,
    output logic           MemtoReg,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     PCSrc,
    output logic           IRWrite,
    output logic           MemWrite,
    output logic           PCWrite,
    output logic           Branch,
    output logic           RegWrite,
    output logic [3:0]     ALUControl,
    output logic [S_W-1:0] state,
    output logic           illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [S_W-1:0] {
        S_RESET  = S_W'(0),
        S_FETCH  = S_W'(1),
        S_DECODE = S_W'(2),
        S_MEMADR = S_W'(3),
        S_MEMRD  = S_W'(4),
        S_MEMWB  = S_W'(5),
        S_MEMWR  = S_W'(6),
        S_EXEC   = S_W'(7),
        S_ALUWB  = S_W'(8),
        S_BRANCH = S_W'(9),
        S_ADDIEX = S_W'(10),
        S_ADDIWB = S_W'(11),
        S_JUMP   = S_W'(12)
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic [3:0] alu_control;
    } ctrl_t;

    state_t     state_q;
    state_t     nxt_state;
    ctrl_t      ctrl_q;
    ctrl_t      nxt_ctrl;
    logic       bad_funct;
    logic       funct_ok;
    logic       op_ok;
    logic [3:0] funct_alu;

    // Moore control word for a given state; EXEC takes the funct-derived ALU op
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] exec_alu,
                                          input logic aluwb_write);
        ctrl_t c;
        c = '0;
        c.alu_control = ALU_ADD;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = exec_alu;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = aluwb_write;
            end
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = ALU_SUB;
                c.pc_src      = 2'b01;
                c.branch      = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c.alu_control = ALU_ADD;
        endcase
        return c;
    endfunction

    // R-type funct decode into ALU op, flagging unsupported functs
    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100110: funct_alu = ALU_XOR;
            6'b100111: funct_alu = ALU_NOR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Next-state sequencing; unsupported opcodes fall back to FETCH
    always_comb begin
        nxt_state = S_FETCH;
        op_ok     = 1'b1;
        case (state_q)
            S_RESET:  nxt_state = S_FETCH;
            S_FETCH:  nxt_state = S_DECODE;
            S_DECODE: begin
                case (OpCode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JUMP;
                    default: begin
                        nxt_state = S_FETCH;
                        op_ok     = 1'b0;
                    end
                endcase
            end
            S_MEMADR: nxt_state = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt_state = S_MEMWB;
            S_EXEC:   nxt_state = S_ALUWB;
            S_ADDIEX: nxt_state = S_ADDIWB;
            default:  nxt_state = S_FETCH;
        endcase
        nxt_ctrl = decode_ctrl(nxt_state, funct_alu, ~bad_funct);
    end

    // State, bad-funct flag and control word registered together so outputs track state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            ctrl_q    <= decode_ctrl(S_RESET, ALU_ADD, 1'b0);
            bad_funct <= 1'b0;
        end else begin
            state_q <= nxt_state;
            ctrl_q  <= nxt_ctrl;
            if (nxt_state == S_EXEC) begin
                bad_funct <= ~funct_ok;
            end
        end
    end

    // Illegal pulse: opcode is only valid once IR is loaded, so DECODE needs it live
    assign illegal = ((state_q == S_DECODE) && !op_ok) || ((state_q == S_EXEC) && bad_funct);

    assign state      = state_q;
    assign IorD       = ctrl_q.iord;
    assign RegDST     = ctrl_q.reg_dst;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign PCSrc      = ctrl_q.pc_src;
    assign IRWrite    = ctrl_q.ir_write;
    assign MemWrite   = ctrl_q.mem_write;
    assign PCWrite    = ctrl_q.pc_write;
    assign Branch     = ctrl_q.branch;
    assign RegWrite   = ctrl_q.reg_write;
    assign ALUControl = ctrl_q.alu_control;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for the multicycle MIPS control FSM.
module tb_mips_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       IorD, RegDST, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       IRWrite, MemWrite, PCWrite, Branch, RegWrite;
    logic [3:0] ALUControl;
    logic [3:0] state;
    logic       illegal;

    int checks = 0;
    int passed = 0;

    mips_control_fsm #(.S_W(4)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct),
        .IorD(IorD), .RegDST(RegDST), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; OpCode = 6'b100011; Funct = 6'b000000;
        tick; tick; tick;
        checks++; if (state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state); else passed++;
        checks++; if ({IorD, RegDST, MemtoReg, ALUSrcA, ALUSrcB, PCSrc} !== 8'h00)
            $display("FAIL reset_selects: got %0h expected 0", {IorD, RegDST, MemtoReg, ALUSrcA, ALUSrcB, PCSrc}); else passed++;
        checks++; if ({IRWrite, MemWrite, PCWrite, Branch, RegWrite} !== 5'b0)
            $display("FAIL reset_enables: got %0b expected 0", {IRWrite, MemWrite, PCWrite, Branch, RegWrite}); else passed++;
        checks++; if (ALUControl !== 4'b0010) $display("FAIL reset_alu: got %0b expected 0010", ALUControl); else passed++;
        checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %0b expected 0", illegal); else passed++;
        rst = 1'b0;
        tick;
        checks++; if (state !== 4'd1) $display("FAIL first_fetch_state: got %0d expected 1", state); else passed++;
        checks++; if ({PCWrite, IRWrite} !== 2'b11) $display("FAIL first_fetch_en: got %0b expected 11", {PCWrite, IRWrite}); else passed++;
        checks++; if (ALUSrcB !== 2'b01) $display("FAIL first_fetch_srcb: got %0b expected 01", ALUSrcB); else passed++;
    endtask

    task automatic test_lw;
        logic [3:0] exp [5];
        exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        OpCode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            checks++; if (state !== exp[i]) $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp[i]); else passed++;
            checks++; if (RegWrite !== (exp[i] == 4'd5)) $display("FAIL lw_regwrite[%0d]: got %0b", i, RegWrite); else passed++;
            checks++; if (MemtoReg !== (exp[i] == 4'd5)) $display("FAIL lw_memtoreg[%0d]: got %0b", i, MemtoReg); else passed++;
            checks++; if (IorD !== (exp[i] == 4'd4)) $display("FAIL lw_iord[%0d]: got %0b", i, IorD); else passed++;
            checks++; if (MemWrite !== 1'b0) $display("FAIL lw_memwrite[%0d]: got %0b expected 0", i, MemWrite); else passed++;
            tick;
        end
        checks++; if (state !== 4'd1) $display("FAIL lw_return: got %0d expected 1", state); else passed++;
    endtask

    task automatic test_rtype;
        logic [5:0] functs [7];
        logic [3:0] alus [7];
        logic [3:0] exp [4];
        functs = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
        alus   = '{4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b1101, 4'b1100, 4'b0111};
        exp    = '{4'd1, 4'd2, 4'd7, 4'd8};
        OpCode = 6'b000000;
        for (int k = 0; k < 7; k++) begin
            Funct = functs[k];
            for (int i = 0; i < 4; i++) begin
                checks++; if (state !== exp[i]) $display("FAIL rtype%0d_state[%0d]: got %0d expected %0d", k, i, state, exp[i]); else passed++;
                checks++; if (ALUControl !== ((exp[i] == 4'd7) ? alus[k] : 4'b0010))
                    $display("FAIL rtype%0d_alu[%0d]: got %0b", k, i, ALUControl); else passed++;
                checks++; if (RegWrite !== (exp[i] == 4'd8)) $display("FAIL rtype%0d_regwrite[%0d]: got %0b", k, i, RegWrite); else passed++;
                checks++; if (RegDST !== (exp[i] == 4'd8)) $display("FAIL rtype%0d_regdst[%0d]: got %0b", k, i, RegDST); else passed++;
                checks++; if (illegal !== 1'b0) $display("FAIL rtype%0d_illegal[%0d]: got %0b expected 0", k, i, illegal); else passed++;
                tick;
            end
        end
        checks++; if (state !== 4'd1) $display("FAIL rtype_return: got %0d expected 1", state); else passed++;
    endtask

    task automatic test_beq;
        logic [3:0] exp [3];
        exp = '{4'd1, 4'd2, 4'd9};
        OpCode = 6'b000100;
        for (int i = 0; i < 3; i++) begin
            checks++; if (state !== exp[i]) $display("FAIL beq_state[%0d]: got %0d expected %0d", i, state, exp[i]); else passed++;
            checks++; if (Branch !== (exp[i] == 4'd9)) $display("FAIL beq_branch[%0d]: got %0b", i, Branch); else passed++;
            checks++; if (PCWrite !== (exp[i] == 4'd1)) $display("FAIL beq_pcwrite[%0d]: got %0b", i, PCWrite); else passed++;
            checks++; if (PCSrc !== ((exp[i] == 4'd9) ? 2'b01 : 2'b00)) $display("FAIL beq_pcsrc[%0d]: got %0b", i, PCSrc); else passed++;
            checks++; if (ALUControl !== ((exp[i] == 4'd9) ? 4'b0110 : 4'b0010)) $display("FAIL beq_alu[%0d]: got %0b", i, ALUControl); else passed++;
            tick;
        end
        checks++; if (state !== 4'd1) $display("FAIL beq_return: got %0d expected 1", state); else passed++;
    endtask

    task automatic test_addi;
        logic [3:0] exp [4];
        exp = '{4'd1, 4'd2, 4'd10, 4'd11};
        OpCode = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== exp[i]) $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, exp[i]); else passed++;
            checks++; if (ALUSrcB !== ((exp[i] == 4'd10) ? 2'b10 : (exp[i] == 4'd2) ? 2'b11 : 2'b01) && exp[i] != 4'd11)
                $display("FAIL addi_srcb[%0d]: got %0b", i, ALUSrcB); else passed++;
            checks++; if (RegWrite !== (exp[i] == 4'd11)) $display("FAIL addi_regwrite[%0d]: got %0b", i, RegWrite); else passed++;
            checks++; if (RegDST !== 1'b0) $display("FAIL addi_regdst[%0d]: got %0b expected 0", i, RegDST); else passed++;
            tick;
        end
        checks++; if (state !== 4'd1) $display("FAIL addi_return: got %0d expected 1", state); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [3:0] jexp [3];
        logic [3:0] sexp [4];
        jexp = '{4'd1, 4'd2, 4'd12};
        sexp = '{4'd1, 4'd2, 4'd3, 4'd6};
        OpCode = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            checks++; if (state !== jexp[i]) $display("FAIL j_state[%0d]: got %0d expected %0d", i, state, jexp[i]); else passed++;
            checks++; if (PCSrc !== ((jexp[i] == 4'd12) ? 2'b10 : 2'b00)) $display("FAIL j_pcsrc[%0d]: got %0b", i, PCSrc); else passed++;
            checks++; if (PCWrite !== (jexp[i] != 4'd2)) $display("FAIL j_pcwrite[%0d]: got %0b", i, PCWrite); else passed++;
            tick;
        end
        OpCode = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            checks++; if (state !== sexp[i]) $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, sexp[i]); else passed++;
            checks++; if (MemWrite !== (sexp[i] == 4'd6)) $display("FAIL sw_memwrite[%0d]: got %0b", i, MemWrite); else passed++;
            checks++; if (IorD !== (sexp[i] == 4'd6)) $display("FAIL sw_iord[%0d]: got %0b", i, IorD); else passed++;
            checks++; if (RegWrite !== 1'b0) $display("FAIL sw_regwrite[%0d]: got %0b expected 0", i, RegWrite); else passed++;
            tick;
        end
        checks++; if (state !== 4'd1) $display("FAIL sw_return: got %0d expected 1", state); else passed++;
    endtask

    task automatic test_illegal;
        OpCode = 6'b111111;
        tick;
        checks++; if (state !== 4'd2) $display("FAIL illop_state: got %0d expected 2", state); else passed++;
        checks++; if (illegal !== 1'b1) $display("FAIL illop_flag: got %0b expected 1", illegal); else passed++;
        tick;
        checks++; if (state !== 4'd1) $display("FAIL illop_next: got %0d expected 1", state); else passed++;
        checks++; if ({illegal, RegWrite, MemWrite} !== 3'b000) $display("FAIL illop_after: got %0b expected 000", {illegal, RegWrite, MemWrite}); else passed++;
        OpCode = 6'b000000; Funct = 6'b111111;
        tick; tick;
        checks++; if (state !== 4'd7) $display("FAIL illfn_state: got %0d expected 7", state); else passed++;
        checks++; if (illegal !== 1'b1) $display("FAIL illfn_flag: got %0b expected 1", illegal); else passed++;
        checks++; if (ALUControl !== 4'b0010) $display("FAIL illfn_alu: got %0b expected 0010", ALUControl); else passed++;
        tick;
        checks++; if (state !== 4'd8) $display("FAIL illfn_wb_state: got %0d expected 8", state); else passed++;
        checks++; if ({RegWrite, illegal} !== 2'b00) $display("FAIL illfn_wb: got %0b expected 00", {RegWrite, illegal}); else passed++;
        tick;
        checks++; if (state !== 4'd1) $display("FAIL illfn_return: got %0d expected 1", state); else passed++;
    endtask

    task automatic test_reset_mid;
        OpCode = 6'b100011; Funct = 6'b000000;
        tick; tick; tick;
        checks++; if (state !== 4'd4) $display("FAIL rstmid_memrd: got %0d expected 4", state); else passed++;
        rst = 1'b1;
        tick;
        checks++; if (state !== 4'd0) $display("FAIL rstmid_state: got %0d expected 0", state); else passed++;
        checks++; if ({RegWrite, MemtoReg, IorD} !== 3'b000) $display("FAIL rstmid_out: got %0b expected 000", {RegWrite, MemtoReg, IorD}); else passed++;
        rst = 1'b0;
        tick;
        checks++; if (state !== 4'd1) $display("FAIL rstmid_fetch: got %0d expected 1", state); else passed++;
        checks++; if (RegWrite !== 1'b0) $display("FAIL rstmid_nowb: got %0b expected 0", RegWrite); else passed++;
    endtask

    initial begin
        test_reset;
        test_lw;
        test_rtype;
        test_beq;
        test_addi;
        test_back_to_back;
        test_illegal;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
